// File: rtl/wavetable_osc.sv
// wavetable_osc: phase-accumulator oscillator reading a 512x16 offset-binary wavetable RAM.
// Each accepted tick fetches one (or two) table entries and emits a signed 16-bit sample.
// Build option: define WAVETABLE_INTERP_EN for linear interpolation between neighbouring
// entries (6-clock latency); left undefined, the block runs in nearest-sample mode
// (3-clock latency). The port list is the same in both builds.
module wavetable_osc #(
  parameter int unsigned PHASE_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               note_on,
  input  logic [PHASE_W-1:0] tuning_word,
  output logic [8:0]         ram_addr,
  output logic               ram_ce,
  output logic               ram_re,
  output logic               ram_we,
  input  logic [15:0]        ram_rdata,
  output logic [15:0]        sample,
  output logic               sample_valid,
  output logic               overrun
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd0  = 3'd1;
  localparam logic [2:0] StCap0 = 3'd2;
`ifdef WAVETABLE_INTERP_EN
  localparam logic [2:0] StRd1  = 3'd3;
  localparam logic [2:0] StCap1 = 3'd4;
  localparam logic [2:0] StMul  = 3'd5;
  localparam int unsigned FracLsb = PHASE_W - 17;
`endif
  localparam logic [2:0] StOut  = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_eff;
  logic [8:0]         addr_d;
  logic               ce_d, re_d;
  logic [15:0]        s0_q, s0_d;
  logic [15:0]        sample_d;

`ifdef WAVETABLE_INTERP_EN
  logic [7:0]         frac_q;
  logic [15:0]        s1_q;
  logic signed [16:0] diff;
  logic signed [25:0] prod_full;
  logic signed [24:0] prod_q;
  logic [15:0]        interp_sum;
  logic               unused_prod;
`endif

  // Next-state, phase update and RAM control decode.
  always_comb begin
    state_d   = state_q;
    phase_eff = note_on ? '0 : phase_q;
    // note_on clears the phase in every state; otherwise phase holds until a tick is accepted
    phase_d   = phase_eff;
    addr_d    = ram_addr;
    s0_d      = s0_q;
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StRd0;
          addr_d  = phase_eff[PHASE_W-1 -: 9];
          phase_d = phase_eff + tuning_word;
        end
      end
      StRd0:  state_d = StCap0;
      StCap0: begin
        s0_d = ram_rdata;
`ifdef WAVETABLE_INTERP_EN
        state_d = StRd1;
        // 9-bit add wraps entry 511 onto entry 0
        addr_d  = ram_addr + 9'd1;
`else
        state_d = StOut;
`endif
      end
`ifdef WAVETABLE_INTERP_EN
      StRd1:  state_d = StCap1;
      StCap1: state_d = StMul;
      StMul:  state_d = StOut;
`endif
      StOut:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Address is held through CAP* because the RAM bank mux decodes the live address MSB.
`ifdef WAVETABLE_INTERP_EN
    ce_d = (state_d == StRd0) || (state_d == StCap0) || (state_d == StRd1) ||
           (state_d == StCap1);
    re_d = (state_d == StRd0) || (state_d == StRd1);
`else
    ce_d = (state_d == StRd0) || (state_d == StCap0);
    re_d = (state_d == StRd0);
`endif
  end

`ifdef WAVETABLE_INTERP_EN
  // Interpolation arithmetic: signed slope times fraction, then rescale onto s0.
  always_comb begin
    diff       = $signed({1'b0, s1_q}) - $signed({1'b0, s0_q});
    prod_full  = diff * $signed({1'b0, frac_q});
    // Only the low 16 bits of s0 + (prod >>> 8) survive, so prod[23:8] is sufficient.
    interp_sum = s0_q + prod_q[23:8];
  end

  assign unused_prod = ^{prod_q[24], prod_q[7:0], prod_full[25]};
`endif

  // Output sample: offset-binary to two's complement by flipping the MSB.
  always_comb begin
    sample_d = sample;
    if (state_q == StOut) begin
`ifdef WAVETABLE_INTERP_EN
      sample_d = interp_sum ^ 16'h8000;
`else
      sample_d = s0_q ^ 16'h8000;
`endif
    end
  end

  // State, phase, RAM control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      ram_addr     <= '0;
      ram_ce       <= 1'b0;
      ram_re       <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      s0_q         <= '0;
`ifdef WAVETABLE_INTERP_EN
      frac_q       <= '0;
      s1_q         <= '0;
      prod_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ram_addr     <= addr_d;
      ram_ce       <= ce_d;
      ram_re       <= re_d;
      sample       <= sample_d;
      sample_valid <= (state_q == StOut);
      // A tick is only accepted in IDLE; any other state (including OUT) drops it.
      overrun      <= tick && (state_q != StIdle);
      s0_q         <= s0_d;
`ifdef WAVETABLE_INTERP_EN
      if ((state_q == StIdle) && tick) frac_q <= phase_eff[FracLsb +: 8];
      if (state_q == StCap1)           s1_q   <= ram_rdata;
      if (state_q == StMul)            prod_q <= prod_full[24:0];
`endif
    end
  end

  assign ram_we = 1'b0;

endmodule

// File: tb/tb_wavetable_osc.sv
// tb_wavetable_osc: randomized and directed checks of wavetable_osc against a behavioural
// model. Build with WAVETABLE_INTERP_EN defined to exercise the interpolating datapath.
module tb_wavetable_osc;

`ifdef WAVETABLE_INTERP_EN
  localparam int Lat    = 6;
  localparam int NRead  = 4;
  localparam bit Interp = 1'b1;
`else
  localparam int Lat    = 3;
  localparam int NRead  = 2;
  localparam bit Interp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, tick, note_on;
  logic [23:0] tuning_word;
  logic [8:0]  ram_addr;
  logic        ram_ce, ram_re, ram_we;
  logic [15:0] ram_rdata;
  logic [15:0] sample;
  logic        sample_valid, overrun;

  wavetable_osc #(.PHASE_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .note_on      (note_on),
    .tuning_word  (tuning_word),
    .ram_addr     (ram_addr),
    .ram_ce       (ram_ce),
    .ram_re       (ram_re),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // RAM model: 1-clock read latency, two banks muxed by the live address MSB.
  logic [15:0] mem [512];
  logic [15:0] bank_lo, bank_hi;
  always @(posedge clk) begin
    if (ram_ce && ram_re) begin
      bank_lo <= mem[{1'b0, ram_addr[7:0]}];
      bank_hi <= mem[{1'b1, ram_addr[7:0]}];
    end
  end
  assign ram_rdata = ram_addr[8] ? bank_hi : bank_lo;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Expected sample for a tick taken at phase ph.
  function automatic logic [15:0] expect_sample(input logic [23:0] ph);
    int a0, fr, s0, s1, v;
    a0 = int'(ph) / 32768;
    fr = (int'(ph) / 128) % 256;
    s0 = int'(mem[a0]);
    s1 = int'(mem[(a0 + 1) % 512]);
    // >>> on a signed int floors the division by 256
    if (Interp) v = s0 + (((s1 - s0) * fr) >>> 8);
    else        v = s0;
    return 16'(v) ^ 16'h8000;
  endfunction

  // Behavioural model state
  bit          armed = 1'b0;
  logic [23:0] m_phase, ph;
  int          next_free, ovr_edge;
  int          due_q[$];
  logic [15:0] val_q[$];
  logic [15:0] cur_sample;
  bit          op_active;
  int          op_k;
  logic [8:0]  op_a0, op_a1;

  // Model update on every active edge, from the inputs the DUT samples.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      armed      = 1'b1;
      m_phase    = '0;
      next_free  = 0;
      ovr_edge   = -1;
      due_q.delete();
      val_q.delete();
      cur_sample = '0;
      op_active  = 1'b0;
    end else if (tick && cyc >= next_free) begin
      ph = note_on ? 24'h0 : m_phase;
      due_q.push_back(cyc + Lat);
      val_q.push_back(expect_sample(ph));
      op_active = 1'b1;
      op_k      = cyc;
      op_a0     = 9'(int'(ph) / 32768);
      op_a1     = 9'((int'(op_a0) + 1) % 512);
      next_free = cyc + Lat + 1;
      m_phase   = ph + tuning_word;
    end else begin
      if (tick)    ovr_edge = cyc;
      if (note_on) m_phase  = '0;
    end
  end

  // Compare process: all DUT outputs every cycle, sampled mid-period.
  int n_valid = 0;
  int n_ovr   = 0;
  bit ev, rd;
  int d;
  initial forever begin
    @(negedge clk);
    if (sample_valid) n_valid++;
    if (overrun)      n_ovr++;
    if (armed) begin
      ev = (due_q.size() > 0) && (due_q[0] == cyc);
      chk("sample_valid", {31'b0, sample_valid}, {31'b0, ev});
      if (ev) begin
        cur_sample = val_q[0];
        void'(due_q.pop_front());
        void'(val_q.pop_front());
      end
      chk("sample", {16'b0, sample}, {16'b0, cur_sample});
      chk("overrun", {31'b0, overrun}, {31'b0, ovr_edge == cyc});
      d  = cyc - op_k;
      rd = op_active && (d < NRead);
      chk("ram_ce", {31'b0, ram_ce}, {31'b0, rd});
      chk("ram_re", {31'b0, ram_re}, {31'b0, rd && (d % 2 == 0)});
      chk("ram_we", {31'b0, ram_we}, 32'd0);
      if (rd) chk("ram_addr", {23'b0, ram_addr}, {23'b0, (d < 2) ? op_a0 : op_a1});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives a one-cycle tick; returns the index of the edge that sampled it.
  task automatic pulse_tick(input bit nt, output int k);
    tick    = 1'b1;
    note_on = nt;
    @(negedge clk);
    tick    = 1'b0;
    note_on = 1'b0;
    k       = cyc;
  endtask

  task automatic wait_valid(input int k, input string name, input logic [15:0] exp);
    int n = 0;
    while (!sample_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 32'(cyc - k), 32'(Lat));
    chk(name, {16'b0, sample}, {16'b0, exp});
  endtask

  int k, v0, o0;

  initial begin
    rst         = 1'b1;
    tick        = 1'b0;
    note_on     = 1'b0;
    tuning_word = '0;
    for (int i = 0; i < 512; i++) mem[i] = 16'((i * 97) ^ 16'h3C00);
    mem[0] = 16'h75B0;
    mem[1] = 16'h7658;
    step(2);
    rst = 1'b0;
    chk("reset sample", {16'b0, sample}, 32'h0);
    chk("reset ram_ce", {31'b0, ram_ce}, 32'h0);

    // Basic stepping
    tuning_word = 24'h008000;
    pulse_tick(1'b0, k);
    wait_valid(k, "basic t1", 16'hF5B0);
    step(10);
    pulse_tick(1'b0, k);
    wait_valid(k, "basic t2", 16'hF658);

    // Interpolation at frac = 0x80
    do_reset();
    tuning_word = 24'h004000;
    pulse_tick(1'b0, k);
    wait_valid(k, "interp t1", 16'hF5B0);
    step(10);
    pulse_tick(1'b0, k);
    wait_valid(k, "interp t2", Interp ? 16'hF604 : 16'hF5B0);

    // Wrap-around: a0 = 511, then the phase wraps to 0x000100
    do_reset();
    mem[511]    = 16'h1234;
    tuning_word = 24'hFF8000;
    pulse_tick(1'b0, k);
    wait_valid(k, "wrap t1", 16'hF5B0);
    step(10);
    tuning_word = 24'h008100;
    pulse_tick(1'b0, k);
    chk("wrap a0", {23'b0, ram_addr}, 32'd511);
    if (Interp) begin
      step(2);
      chk("wrap a1", {23'b0, ram_addr}, 32'd0);
    end
    wait_valid(k, "wrap t2", 16'h9234);
    step(10);
    pulse_tick(1'b0, k);
    chk("wrap phase", {23'b0, ram_addr}, 32'd0);
    wait_valid(k, "wrap t3", Interp ? 16'hF5B1 : 16'hF5B0);

    // Overrun: ticks 3 clocks apart
    do_reset();
    tuning_word = 24'h008000;
    step(1);
    v0 = n_valid;
    o0 = n_ovr;
    for (int i = 0; i < 6; i++) begin
      pulse_tick(1'b0, k);
      step(2);
    end
    step(12);
    chk("overrun accepted", 32'(n_valid - v0), Interp ? 32'd2 : 32'd3);
    chk("overrun pulses", 32'(n_ovr - o0), Interp ? 32'd4 : 32'd3);

    // Note-on together with tick
    do_reset();
    tuning_word = 24'h123456;
    pulse_tick(1'b0, k);
    step(12);
    pulse_tick(1'b1, k);
    chk("note_on addr", {23'b0, ram_addr}, 32'd0);
    step(12);
    pulse_tick(1'b0, k);
    chk("note_on next addr", {23'b0, ram_addr}, 32'h024);
    step(12);

    // Reset in the last capture state
    do_reset();
    tuning_word = 24'h3A5000;
    pulse_tick(1'b0, k);
    step(12);
    pulse_tick(1'b0, k);
    step(NRead - 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst ram_ce", {31'b0, ram_ce}, 32'h0);
    chk("midrst ram_re", {31'b0, ram_re}, 32'h0);
    chk("midrst ram_addr", {23'b0, ram_addr}, 32'h0);
    chk("midrst sample", {16'b0, sample}, 32'h0);
    v0 = n_valid;
    step(12);
    chk("midrst no valid", 32'(n_valid - v0), 32'd0);
    pulse_tick(1'b0, k);
    chk("midrst phase", {23'b0, ram_addr}, 32'd0);
    step(12);

    // Randomized traffic against the model
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom % 400) == 0;
      tick    = ($urandom % 4) == 0;
      note_on = ($urandom % 25) == 0;
      if (($urandom % 50) == 0) tuning_word = 24'($urandom);
      @(negedge clk);
    end
    rst     = 1'b0;
    tick    = 1'b0;
    note_on = 1'b0;
    step(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1);
  end

endmodule
